alu_cmd_driver: RTL
===================

Name: alu_cmd_driver

Overview:
Sequential initiator for the team's 8-bit combinational ALU (opcode-select, A/B operands, y/carry result). It accepts operation commands from a host over a valid/ready handshake and drives registered operands and opcode onto the ALU. After a settle window it samples y/carry and returns them with status over a second valid/ready handshake. It sits between the host/test controller and the ALU instance.

Parameters:
DW, 8, operand/result width; must match the ALU width.
SETTLE_CYCLES, 1, number of clock edges between driving ALU inputs and sampling its outputs; legal range 1..15.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  block can accept a command
cmd_a  in  DW  operand A
cmd_b  in  DW  operand B
cmd_op  in  3  opcode (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7)
alu_a  out  DW  registered operand A to ALU
alu_b  out  DW  registered operand B to ALU
alu_s  out  3  registered opcode to ALU
alu_y  in  DW  ALU result
alu_carry  in  1  ALU carry/borrow
rsp_valid  out  1  response valid
rsp_ready  in  1  host accepts response
rsp_y  out  DW  captured result
rsp_carry  out  1  captured carry
rsp_zero  out  1  rsp_y == 0
rsp_err  out  1  self-check mismatch (see Optional Feature)
op_cnt  out  CNT_W  completed responses, wraps

Behaviour:
- Reset (async assert, sync release): state=IDLE, cmd_ready=1, rsp_valid=0, alu_a/alu_b/alu_s=0, rsp_y=0, rsp_carry=0, rsp_zero=0, rsp_err=0, op_cnt=0, settle counter=0.
- FSM: IDLE -> WAIT -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at an edge: alu_a<=cmd_a, alu_b<=cmd_b, alu_s<=cmd_op, cnt<=SETTLE_CYCLES, go to WAIT.
- WAIT: cmd_ready=0. Decrement cnt each edge. At the edge where cnt==1: rsp_y<=alu_y, rsp_carry<=alu_carry, rsp_zero<=(alu_y==0), rsp_valid<=1, go to RESP.
- RESP: cmd_ready=0. rsp_* are held stable while rsp_valid&!rsp_ready. On rsp_valid&rsp_ready: rsp_valid<=0, op_cnt<=op_cnt+1 (wraps to 0), go to IDLE.
- Latency: the command handshake at edge N gives rsp_valid high after edge N+SETTLE_CYCLES. Minimum command-to-command spacing is SETTLE_CYCLES+2 cycles.
- alu_a/alu_b/alu_s hold their last command's values in IDLE and RESP. They change only on a command handshake.
- cmd_ready is a pure function of state (high only in IDLE). It has no combinational path from rsp_ready.
- A response handshake and a new command never occur in the same cycle. The next command is accepted no earlier than the cycle after the rsp handshake.
- Reset mid-WAIT or mid-RESP: the in-flight command is dropped, with no response, and all outputs return to reset values.
- All opcodes are legal. No error is raised on opcode.

Optional Feature:
ALU_CHECK_EN
- Defined: an internal reference model computes the expected {carry,y} from alu_a/alu_b/alu_s.
  - ADD: carry = bit DW of the (DW+1)-bit sum.
  - SUB: carry = bit DW of the (DW+1)-bit A-B, i.e. 1 when A<B.
  - All other opcodes: carry=0; SHL/SHR are logical.
  - At capture, rsp_err<=1 if the expected value differs from {alu_carry,alu_y}, else 0. rsp_err is held with the response.
- Undefined: rsp_err is constant 0 and no model logic is synthesised.

Decomposition:
- Shared package alu_pkg: DW default constant; opcode localparams OP_ADD..OP_SHR; FSM state enum (IDLE, WAIT, RESP).
- One sub-module, alu_ref_model: combinational expected-result function. It is instantiated only under ALU_CHECK_EN and is reusable by the verification bench.

Test Plan:
- ADD 0xFF+0x01, SETTLE_CYCLES=1, rsp_ready=1 -> rsp_valid one edge after accept; rsp_y=0x00, rsp_carry=1, rsp_zero=1; op_cnt=1.
- SUB 0x05-0x07 -> rsp_y=0xFE, rsp_carry=1, rsp_zero=0. SHL 0x81 -> rsp_y=0x02, rsp_carry=0.
- Backpressure: XOR 0xF0^0x3C with rsp_ready low 5 cycles -> rsp_y=0xCC stable, rsp_valid held, cmd_ready=0 throughout; after the handshake, cmd_ready=1 next cycle.
- SETTLE_CYCLES=4, cmd_valid held high with a stream of 3 commands -> responses exactly 4 edges after each accept, spacing ≥6 cycles, op_cnt=3.
- Assert rst_n low during WAIT for an AND command -> no rsp_valid; all outputs at reset values; the next command completes normally.
- ALU_CHECK_EN defined, bench ALU model forces y=0x00 for OR 0x0F|0xF0 -> rsp_err=1. A correct ALU on the same command -> rsp_err=0.
- CNT_W=2, 5 completed responses -> op_cnt wraps to 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver and its reference model:
// default data width, opcode encodings and the driver FSM state type.
package alu_pkg;

    localparam int unsigned DW_DEF = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational reference ALU: expected {carry, y} for a given opcode and
// operands. ADD/SUB report carry/borrow from bit DW of the widened result;
// every other opcode reports carry 0. Shifts are logical, by one position.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [2:0]    i_op,
    output logic [DW-1:0] o_y,
    output logic          o_carry
);

    logic [DW:0] w_ext;

    // Opcode decode into expected result and carry
    always_comb begin
        w_ext   = '0;
        o_y     = '0;
        o_carry = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_ext   = {1'b0, i_a} + {1'b0, i_b};
                o_y     = w_ext[DW-1:0];
                o_carry = w_ext[DW];
            end
            OP_SUB: begin
                w_ext   = {1'b0, i_a} - {1'b0, i_b};
                o_y     = w_ext[DW-1:0];
                o_carry = w_ext[DW];
            end
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NOT:  o_y = ~i_a;
            OP_SHL:  o_y = i_a << 1;
            OP_SHR:  o_y = i_a >> 1;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequential initiator for the combinational ALU. Accepts a command over a
// valid/ready handshake, drives registered operands/opcode to the ALU, waits
// SETTLE_CYCLES edges, captures y/carry and returns them with status over a
// second valid/ready handshake.
// Optional build macro ALU_CHECK_EN: adds an internal reference model and
// flags rsp_err when the ALU result differs from it; otherwise rsp_err is 0.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int unsigned DW            = DW_DEF,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DW-1:0]    cmd_a,
    input  logic [DW-1:0]    cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [DW-1:0]    alu_a,
    output logic [DW-1:0]    alu_b,
    output logic [2:0]       alu_s,
    input  logic [DW-1:0]    alu_y,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_y,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_cnt
);

    // Settle counter is sized for the full legal range 1..15
    localparam int unsigned SCW = 4;

    state_t            r_state;
    state_t            w_next_state;
    logic [SCW-1:0]    r_cnt;
    logic [DW-1:0]     r_alu_a;
    logic [DW-1:0]     r_alu_b;
    logic [2:0]        r_alu_s;
    logic              r_rsp_valid;
    logic [DW-1:0]     r_rsp_y;
    logic              r_rsp_carry;
    logic              r_rsp_zero;
    logic [CNT_W-1:0]  r_op_cnt;

    logic              w_cmd_ready;
    logic              w_cmd_fire;
    logic              w_capture;
    logic              w_rsp_fire;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; cmd_ready depends on state only
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_cmd_fire   = 1'b0;
        w_capture    = 1'b0;
        w_rsp_fire   = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_cmd_fire   = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == SCW'(1)) begin
                    w_capture    = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_fire   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ALU operand/opcode registers, updated only on a command handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a <= '0;
            r_alu_b <= '0;
            r_alu_s <= '0;
        end else if (w_cmd_fire) begin
            r_alu_a <= cmd_a;
            r_alu_b <= cmd_b;
            r_alu_s <= cmd_op;
        end
    end

    // Settle counter: loaded on accept, counts down while waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cmd_fire) begin
            r_cnt <= SCW'(SETTLE_CYCLES);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - SCW'(1);
        end
    end

    // Response capture and hold until the host takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_zero  <= 1'b0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= alu_y;
            r_rsp_carry <= alu_carry;
            r_rsp_zero  <= (alu_y == '0);
        end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Completed-response counter, wraps at 2**CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_cnt <= '0;
        end else if (w_rsp_fire) begin
            r_op_cnt <= r_op_cnt + CNT_W'(1);
        end
    end

`ifdef ALU_CHECK_EN
    logic [DW-1:0] w_exp_y;
    logic          w_exp_carry;
    logic          r_rsp_err;

    alu_ref_model #(
        .DW (DW)
    ) u_ref (
        .i_a     (r_alu_a),
        .i_b     (r_alu_b),
        .i_op    (r_alu_s),
        .o_y     (w_exp_y),
        .o_carry (w_exp_carry)
    );

    // Self-check flag, captured alongside the response and held with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err <= ({w_exp_carry, w_exp_y} != {alu_carry, alu_y});
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = w_cmd_ready;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign rsp_carry = r_rsp_carry;
    assign rsp_zero  = r_rsp_zero;
    assign op_cnt    = r_op_cnt;

endmodule
